ddr2_addr_cmd_fifo_p: RTL and testbench
=======================================

Name: ddr2_addr_cmd_fifo_p

Overview:
Parametrised single-clock address/command FIFO between the user interface and the DDR2 controller FSM. It replaces the fixed 36x16 hard-FIFO address path with a register/LUT-RAM FIFO of configurable depth, width and compare field. It tags each entry with a row-conflict bit and exposes occupancy, a programmable almost-full level and first-word-fall-through output. The controller pops entries with ctrl_af_rden.

Parameters:
DATA_W, 36, stored word width; bit DATA_W-1 = conflict bit, bits [DATA_W-2:0] = user command+address
COL_W, 10, column-address width; compare field LSB
CMP_W, 16, chip+bank+row width compared for conflict; field = [COL_W+CMP_W-1:COL_W]; COL_W+CMP_W <= DATA_W-1
DEPTH, 16, entries; power of 2, >= 4
AF_LEVEL, 12, af_almost_full asserts when occupancy >= AF_LEVEL; 1 <= AF_LEVEL <= DEPTH

Ports:
clk0  in  1  single clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
app_af_addr  in  DATA_W  user word; bit DATA_W-1 ignored
app_af_wren  in  1  write request
ctrl_af_rden  in  1  pop head entry
af_addr  out  DATA_W  head entry (FWFT); all-zero while af_empty=1
af_empty  out  1  FIFO holds no readable entry
af_almost_full  out  1  registered occupancy >= AF_LEVEL
af_count  out  $clog2(DEPTH)+1  readable entries, 0..DEPTH

Behaviour:
- Reset (rst=1 at edge): pointers, af_count=0, staging valid=0, compare-valid=0, af_empty=1, af_almost_full=0, af_addr=0. Reset mid-operation discards all entries, including the one in staging; next write after reset is treated as first write.
- Write path, 2 stages. Edge k: app_af_wren=1 loads staging reg {app_af_addr, valid=1}. Edge k+1: staging word written to RAM at wr_ptr, af_count+1, af_empty=0 visible after edge k+1. Write-to-output latency = 2 edges.
- Conflict bit computed in staging: 1 if compare field differs from last accepted write's field, or compare-valid=0; else 0. Stored word = {conflict, staging[DATA_W-2:0]}. Compare register and compare-valid update only when the staging word is committed.
- Back-to-back writes every cycle sustained at full rate.
- Read: ctrl_af_rden=1 with af_empty=0 at edge -> rd_ptr+1, af_count-1, next head presented after the same edge. rden while empty: ignored, no state change.
- Simultaneous commit and pop: af_count unchanged; commit allowed even when af_count=DEPTH (slot freed same edge).
- Full: staging commit with af_count=DEPTH and no pop -> word dropped, af_count stays DEPTH, compare register not updated.
- Pointers wrap modulo DEPTH; af_count saturates 0..DEPTH by construction.
- af_almost_full registered from next-state occupancy plus staging valid, so it asserts on the same edge the threshold is reached; users must stop writing within 1 cycle of assertion.
- af_empty registered; af_empty = (af_count==0).

Optional Feature:
AF_ERR_FLAGS_EN: when defined, adds outputs af_overflow and af_underflow (1 bit each). af_overflow sets on a dropped commit, af_underflow sets on rden while empty; both sticky until rst, reset value 0. When undefined, ports and logic are absent; all other behaviour identical.

Test Plan:
- rst, write 0x0_0000_0400 then 0x0_0000_0401 on consecutive cycles -> af_empty falls 2 edges after first wren; af_addr = 0x8_0000_0400 (first, conflict=1), then 0x0_0000_0401 after pop (same row/bank, conflict=0).
- Write addresses with field [25:10] = 0x0001, 0x0002, 0x0002 -> stored conflict bits 1,1,0.
- 12 writes, no reads (DEPTH=16, AF_LEVEL=12) -> af_almost_full=1 at af_count=12; pop one -> deasserts next edge at af_count=11.
- Fill to 16, write a 17th -> af_count stays 16, 17th never read; with AF_ERR_FLAGS_EN af_overflow=1. Then write+pop same cycle at full -> accepted, count stays 16.
- Pop while empty -> af_count=0, af_addr=0; with AF_ERR_FLAGS_EN af_underflow=1.
- 5 writes, assert rst for 1 cycle during 6th write -> af_empty=1, af_count=0; next write has conflict=1.

Source files
------------

// File: rtl/ddr2_addr_cmd_fifo_p_if.sv
// Address/command FIFO handshake bundle.
// master = user/controller side, slave = FIFO.
interface ddr2_addr_cmd_fifo_p_if #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] app_af_addr;
  logic              app_af_wren;
  logic              ctrl_af_rden;
  logic [DATA_W-1:0] af_addr;
  logic              af_empty;
  logic              af_almost_full;
  logic [CW-1:0]     af_count;

  modport master (
    output app_af_addr,
    output app_af_wren,
    output ctrl_af_rden,
    input  af_addr,
    input  af_empty,
    input  af_almost_full,
    input  af_count
  );

  modport slave (
    input  app_af_addr,
    input  app_af_wren,
    input  ctrl_af_rden,
    output af_addr,
    output af_empty,
    output af_almost_full,
    output af_count
  );
endinterface

// File: rtl/ddr2_addr_cmd_fifo_p.sv
// Parametrised FWFT address/command FIFO with row-conflict tagging.
// Optional AF_ERR_FLAGS_EN adds sticky af_overflow/af_underflow.
module ddr2_addr_cmd_fifo_p #(
  parameter int DATA_W   = 36,
  parameter int COL_W    = 10,
  parameter int CMP_W    = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic clk0,
  input  logic rst,
`ifdef AF_ERR_FLAGS_EN
  output logic af_overflow,
  output logic af_underflow,
`endif
  ddr2_addr_cmd_fifo_p_if.slave af
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-2:0] stg;
  logic              stg_vld;
  logic [CMP_W-1:0]  cmp;
  logic              cmp_vld;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic [CW:0]       occ_nxt;
  logic              empty_q;
  logic              afull_q;
  logic              full;
  logic              pop;
  logic              commit;
  logic              conf;
  logic              drop;
  logic              pop_empty;
  logic              unused_top;

  // The top user bit is replaced by the conflict tag.
  assign unused_top = af.app_af_addr[DATA_W-1];

  assign full      = cnt == CW'(DEPTH);
  assign pop       = af.ctrl_af_rden && !empty_q;
  assign commit    = stg_vld && (!full || pop);
  assign drop      = stg_vld && full && !pop;
  assign pop_empty = af.ctrl_af_rden && empty_q;
  assign conf      = !cmp_vld ||
                     (stg[COL_W+CMP_W-1:COL_W] != cmp);

  // Next occupancy from commit/pop combination.
  always_comb begin
    cnt_nxt = cnt;
    if (commit && !pop)
      cnt_nxt = cnt + CW'(1);
    else if (!commit && pop)
      cnt_nxt = cnt - CW'(1);
  end

  assign occ_nxt = {1'b0, cnt_nxt} +
                   (CW+1)'(af.app_af_wren);

  // Staging register: first stage of the write path.
  always_ff @(posedge clk0) begin
    if (rst) begin
      stg_vld <= 1'b0;
    end else begin
      stg_vld <= af.app_af_wren;
      if (af.app_af_wren)
        stg <= af.app_af_addr[DATA_W-2:0];
    end
  end

  // Storage array, written with the tagged word on commit.
  always_ff @(posedge clk0) begin
    if (commit && !rst)
      mem[wr_ptr] <= {conf, stg};
  end

  // Pointers, occupancy, compare state and status flags.
  always_ff @(posedge clk0) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      cmp     <= '0;
      cmp_vld <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
    end else begin
      if (commit) begin
        wr_ptr  <= wr_ptr + AW'(1);
        cmp     <= stg[COL_W+CMP_W-1:COL_W];
        cmp_vld <= 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      cnt     <= cnt_nxt;
      empty_q <= cnt_nxt == '0;
      afull_q <= occ_nxt >= (CW+1)'(AF_LEVEL);
    end
  end

`ifdef AF_ERR_FLAGS_EN
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk0) begin
    if (rst) begin
      af_overflow  <= 1'b0;
      af_underflow <= 1'b0;
    end else begin
      if (drop)
        af_overflow <= 1'b1;
      if (pop_empty)
        af_underflow <= 1'b1;
    end
  end
`else
  logic unused_err;
  assign unused_err = drop ^ pop_empty;
`endif

  assign af.af_addr        = empty_q ? '0 : mem[rd_ptr];
  assign af.af_empty       = empty_q;
  assign af.af_almost_full = afull_q;
  assign af.af_count       = cnt;
endmodule

// File: tb/tb_ddr2_addr_cmd_fifo_p.sv
// Directed scoreboard bench for ddr2_addr_cmd_fifo_p.
// Expected words are pushed on write, compared on pop.
module tb_ddr2_addr_cmd_fifo_p;
  logic clk0 = 1'b0;
  logic rst  = 1'b0;
`ifdef AF_ERR_FLAGS_EN
  logic af_overflow;
  logic af_underflow;
`endif

  ddr2_addr_cmd_fifo_p_if #(.DATA_W(36), .DEPTH(16)) bus ();

  ddr2_addr_cmd_fifo_p #(
    .DATA_W(36), .COL_W(10), .CMP_W(16),
    .DEPTH(16), .AF_LEVEL(12)
  ) dut (
    .clk0(clk0),
    .rst(rst),
`ifdef AF_ERR_FLAGS_EN
    .af_overflow(af_overflow),
    .af_underflow(af_underflow),
`endif
    .af(bus.slave)
  );

  always #5 clk0 = ~clk0;

  int checks = 0;
  int errors = 0;
  logic [35:0] q[$];
  logic [15:0] mlast;
  bit          mvld;

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    mvld = 1'b0;
  endtask

  // Drive one write for one edge; model conflict tag.
  task automatic wr(input logic [35:0] a, input bit keep);
    logic [15:0] f;
    logic        c;
    f = a[25:10];
    c = !mvld || (f != mlast);
    if (keep) begin
      q.push_back({c, a[34:0]});
      mlast = f;
      mvld  = 1'b1;
    end
    bus.app_af_addr = a;
    bus.app_af_wren = 1'b1;
    tick();
    bus.app_af_wren = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    logic [35:0] e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=pop expected=no_data", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_empty"}, 64'(bus.af_empty), 64'd0);
      chk({tag, "_addr"}, 64'(bus.af_addr), 64'(e));
    end
    bus.ctrl_af_rden = 1'b1;
    tick();
    bus.ctrl_af_rden = 1'b0;
  endtask

  initial begin
    bus.app_af_addr  = '0;
    bus.app_af_wren  = 1'b0;
    bus.ctrl_af_rden = 1'b0;
    mvld  = 1'b0;
    mlast = '0;
    #2;

    // Reset state
    do_reset();
    tick();
    chk("rst_empty", 64'(bus.af_empty), 64'd1);
    chk("rst_count", 64'(bus.af_count), 64'd0);
    chk("rst_afull", 64'(bus.af_almost_full), 64'd0);
    chk("rst_addr", 64'(bus.af_addr), 64'd0);
`ifdef AF_ERR_FLAGS_EN
    chk("rst_ovf", 64'(af_overflow), 64'd0);
    chk("rst_unf", 64'(af_underflow), 64'd0);
`endif

    // Two-edge latency and conflict tagging
    wr(36'h0_0000_0400, 1'b1);
    chk("lat_empty_k", 64'(bus.af_empty), 64'd1);
    wr(36'h0_0000_0401, 1'b1);
    chk("lat_empty_k1", 64'(bus.af_empty), 64'd0);
    chk("lat_count_k1", 64'(bus.af_count), 64'd1);
    chk("first_word", 64'(bus.af_addr),
        64'h8_0000_0400);
    tick();
    chk("two_count", 64'(bus.af_count), 64'd2);
    pop_chk("p1");
    chk("second_word", 64'(bus.af_addr),
        64'h0_0000_0401);
    pop_chk("p2");
    chk("drained", 64'(bus.af_empty), 64'd1);

    // Conflict sequence 1,1,0
    do_reset();
    wr(36'h0_0000_0400, 1'b1);
    wr(36'h0_0000_0800, 1'b1);
    wr(36'h0_0000_0805, 1'b1);
    tick();
    chk("cf_count", 64'(bus.af_count), 64'd3);
    pop_chk("cf0");
    pop_chk("cf1");
    pop_chk("cf2");

    // Almost-full threshold
    do_reset();
    for (int i = 0; i < 12; i++)
      wr({$urandom, $urandom}, 1'b1);
    tick();
    chk("af12_count", 64'(bus.af_count), 64'd12);
    chk("af12_flag", 64'(bus.af_almost_full), 64'd1);
    pop_chk("af_pop");
    chk("af11_count", 64'(bus.af_count), 64'd11);
    chk("af11_flag", 64'(bus.af_almost_full), 64'd0);

    // Fill to full, then drop one
    for (int i = 0; i < 5; i++)
      wr({28'h0, 8'(i)} << 10, 1'b1);
    wr(36'h0_0ABC_D000, 1'b0);
    tick();
    tick();
    chk("full_count", 64'(bus.af_count), 64'd16);
`ifdef AF_ERR_FLAGS_EN
    chk("ovf_set", 64'(af_overflow), 64'd1);
`endif

    // Commit and pop on the same edge while full
    wr(36'h0_0123_4567, 1'b1);
    pop_chk("full_pop");
    chk("full_wp_count", 64'(bus.af_count), 64'd16);
    for (int i = 0; i < 16; i++)
      pop_chk("drain");
    chk("drain_empty", 64'(bus.af_empty), 64'd1);
    chk("drain_count", 64'(bus.af_count), 64'd0);

    // Pop while empty
`ifdef AF_ERR_FLAGS_EN
    chk("unf_clear", 64'(af_underflow), 64'd0);
`endif
    bus.ctrl_af_rden = 1'b1;
    tick();
    bus.ctrl_af_rden = 1'b0;
    chk("ue_count", 64'(bus.af_count), 64'd0);
    chk("ue_addr", 64'(bus.af_addr), 64'd0);
    chk("ue_empty", 64'(bus.af_empty), 64'd1);
`ifdef AF_ERR_FLAGS_EN
    chk("unf_set", 64'(af_underflow), 64'd1);
`endif

    // Reset during the sixth write
    do_reset();
    for (int i = 0; i < 5; i++)
      wr(36'h0_0000_0400 + 36'(i), 1'b1);
    bus.app_af_addr = 36'h0_0000_0405;
    bus.app_af_wren = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.app_af_wren = 1'b0;
    q.delete();
    mvld = 1'b0;
    tick();
    chk("mr_empty", 64'(bus.af_empty), 64'd1);
    chk("mr_count", 64'(bus.af_count), 64'd0);
`ifdef AF_ERR_FLAGS_EN
    chk("mr_ovf", 64'(af_overflow), 64'd0);
`endif
    wr(36'h0_0000_0406, 1'b1);
    tick();
    chk("mr_count1", 64'(bus.af_count), 64'd1);
    pop_chk("mr_first");
    chk("mr_end", 64'(bus.af_empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
